// File: rtl/uart_alu_ctrl_pkg.sv
// Shared types and constants for the UART packet sequencer
// that feeds the 32-bit ALU.
package uart_alu_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int OPND_W = 32;
  localparam logic [15:0] MAX_LEN = 16'd1024;
  localparam logic [15:0] HDR_BYTES = 16'd4;

  localparam logic [7:0] OPC_ECHO = 8'hEC;
  localparam logic [7:0] OPC_ADD = 8'hAD;
  localparam logic [7:0] OPC_MUL = 8'h4D;
  localparam logic [7:0] OPC_DIV = 8'h0D;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_MUL,
    ALU_DIV
  } alu_op_e;

  typedef enum logic [1:0] {
    K_ECHO,
    K_ALU,
    K_BAD
  } pkt_kind_e;

  typedef enum logic [3:0] {
    S_OPCODE,
    S_RSV,
    S_LEN_LO,
    S_LEN_HI,
    S_DRAIN,
    S_ECHO,
    S_OPND,
    S_ALU_REQ,
    S_ALU_WAIT,
    S_TX
  } ctrl_state_e;

  // ALU packets carry whole 32-bit operands, at least one
  function automatic logic len_ok(
    pkt_kind_e k,
    logic [15:0] len
  );
    logic ok;
    ok = (len >= HDR_BYTES) && (len <= MAX_LEN);
    unique case (k)
      K_ECHO: len_ok = ok;
      K_ALU: len_ok = ok && (len >= 16'd8)
                    && (len[1:0] == 2'b00);
      default: len_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_ctrl.sv
// Packet sequencer: parses UART commands, folds operands
// through the ALU and serialises the 32-bit result to TX.
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [1:0]        alu_op_o,
  output logic [OPND_W-1:0] alu_a_o,
  output logic [OPND_W-1:0] alu_b_o,
  output logic              alu_valid_o,
  input  logic              alu_ready_i,
  input  logic [OPND_W-1:0] alu_result_i,
  input  logic              alu_result_valid_i,
  output logic              busy_o,
  output logic              err_o
);

  ctrl_state_e state_q, state_d;
  pkt_kind_e kind_q, kind_d;
  alu_op_e op_q, op_d;
  logic [7:0] len_lo_q, len_lo_d;
  logic [15:0] left_q, left_d;
  logic [OPND_W-1:0] opnd_q, opnd_d;
  logic [OPND_W-1:0] acc_q, acc_d;
  logic [1:0] idx_q, idx_d;
  logic first_q, first_d;
  logic err_q, err_d;

  logic rx_fire;
  logic [15:0] len;
  logic [OPND_W-1:0] opnd_nx;

  assign rx_fire = rx_valid_i & rx_ready_o;
  assign len = {rx_data_i, len_lo_q};
  assign opnd_nx = {rx_data_i, opnd_q[OPND_W-1:DATA_W]};

  assign alu_op_o = op_q;
  assign alu_a_o = acc_q;
  assign alu_b_o = opnd_q;
  assign busy_o = (state_q != S_OPCODE);
  assign err_o = err_q;

  always_comb begin
    state_d = state_q;
    kind_d = kind_q;
    op_d = op_q;
    len_lo_d = len_lo_q;
    left_d = left_q;
    opnd_d = opnd_q;
    acc_d = acc_q;
    idx_d = idx_q;
    first_d = first_q;
    err_d = 1'b0;
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o = '0;
    alu_valid_o = 1'b0;
    unique case (state_q)
      S_OPCODE: begin
        rx_ready_o = 1'b1;
        if (rx_fire) begin
          state_d = S_RSV;
          op_d = ALU_ADD;
          unique case (1'b1)
            rx_data_i == OPC_ECHO: kind_d = K_ECHO;
            rx_data_i == OPC_ADD: kind_d = K_ALU;
            rx_data_i == OPC_MUL: begin
              kind_d = K_ALU;
              op_d = ALU_MUL;
            end
            rx_data_i == OPC_DIV: begin
              kind_d = K_ALU;
              op_d = ALU_DIV;
            end
            default: kind_d = K_BAD;
          endcase
        end
      end
      S_RSV: begin
        rx_ready_o = 1'b1;
        if (rx_fire) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready_o = 1'b1;
        if (rx_fire) begin
          len_lo_d = rx_data_i;
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        rx_ready_o = 1'b1;
        if (rx_fire) begin
          left_d = len - HDR_BYTES;
          idx_d = '0;
          first_d = 1'b1;
          // Too-short packets have no payload left to drain
          if (!len_ok(kind_q, len)) begin
            err_d = 1'b1;
            if (len <= HDR_BYTES) begin
              left_d = '0;
              state_d = S_OPCODE;
            end else begin
              state_d = S_DRAIN;
            end
          end else if (kind_q == K_ECHO) begin
            state_d = (len == HDR_BYTES) ? S_OPCODE : S_ECHO;
          end else begin
            state_d = S_OPND;
          end
        end
      end
      S_DRAIN: begin
        rx_ready_o = 1'b1;
        if (rx_fire) begin
          left_d = left_q - 16'd1;
          if (left_q == 16'd1) state_d = S_OPCODE;
        end
      end
      S_ECHO: begin
        rx_ready_o = tx_ready_i;
        tx_valid_o = rx_valid_i;
        tx_data_o = rx_data_i;
        if (rx_fire) begin
          left_d = left_q - 16'd1;
          if (left_q == 16'd1) state_d = S_OPCODE;
        end
      end
      S_OPND: begin
        rx_ready_o = 1'b1;
        if (rx_fire) begin
          opnd_d = opnd_nx;
          idx_d = idx_q + 2'd1;
          left_d = left_q - 16'd1;
          if (idx_q == 2'd3) begin
            if (first_q) begin
              acc_d = opnd_nx;
              first_d = 1'b0;
              if (left_q == 16'd1) state_d = S_TX;
            end else begin
              state_d = S_ALU_REQ;
            end
          end
        end
      end
      S_ALU_REQ: begin
        alu_valid_o = 1'b1;
        if (alu_ready_i) state_d = S_ALU_WAIT;
      end
      S_ALU_WAIT: begin
        if (alu_result_valid_i) begin
          acc_d = alu_result_i;
          state_d = (left_q == '0) ? S_TX : S_OPND;
        end
      end
      S_TX: begin
        tx_valid_o = 1'b1;
        tx_data_o = acc_q[{idx_q, 3'b000} +: DATA_W];
        if (tx_ready_i) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_OPCODE;
        end
      end
      default: state_d = S_OPCODE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_OPCODE;
      kind_q <= K_BAD;
      op_q <= ALU_ADD;
      len_lo_q <= '0;
      left_q <= '0;
      opnd_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      first_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q <= kind_d;
      op_q <= op_d;
      len_lo_q <= len_lo_d;
      left_q <= left_d;
      opnd_q <= opnd_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      first_q <= first_d;
      err_q <= err_d;
    end
  end

endmodule
